// File: rtl/vend_controller.sv
// Vending sequencer: coin qualification, credit/stock tracking, dispense req/ack, nickel change.
// Optional CREDIT idle timeout with auto-refund is enabled by defining VEND_TIMEOUT_EN.
module vend_controller #(
  parameter int PRICE_NICKELS = 4,
  parameter int STOCK_INIT    = 8,
  parameter int TIMEOUT_CYC   = 1000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       nickle_i,
  input  logic       dime_i,
  input  logic       quarter_i,
  input  logic       refund_i,
  input  logic       vend_ack_i,
  output logic       vend_req_o,
  output logic       change_o,
  output logic       coin_reject_o,
  output logic [3:0] credit_o,
  output logic [3:0] stock_o,
  output logic       sold_out_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  localparam logic [3:0] PRICE = 4'(PRICE_NICKELS);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_credit;
  logic [3:0] w_credit_next;
  logic [3:0] r_stock;
  logic [3:0] w_stock_next;

  logic [1:0] w_coin_cnt;
  logic       w_coin_any;
  logic       w_coin_ok;
  logic [2:0] w_coin_val;
  logic [3:0] w_credit_add;
  logic [3:0] w_credit_left;
  logic       w_tmo_hit;

  assign w_coin_cnt = 2'(nickle_i) + 2'(dime_i) + 2'(quarter_i);
  assign w_coin_any = (w_coin_cnt != 2'd0);
  assign w_coin_val = nickle_i ? 3'd1 : (dime_i ? 3'd2 : (quarter_i ? 3'd5 : 3'd0));

  // A single coin is only taken when there is something to buy and no dispense/change in flight.
  assign w_coin_ok = (w_coin_cnt == 2'd1) &&
                     (((r_state == IDLE) && (r_stock != 4'd0)) || (r_state == CREDIT));

  assign w_credit_add  = r_credit + 4'(w_coin_val);
  assign w_credit_left = r_credit - PRICE;

`ifdef VEND_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  // Held at zero outside CREDIT, so entering CREDIT always starts a fresh count.
  always_ff @(posedge clk_i) begin
    if (rst_i || (r_state != CREDIT) || w_coin_ok) begin
      r_tmo_cnt <= '0;
    end else if (!w_tmo_hit) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  assign w_tmo_hit = (r_state == CREDIT) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_credit <= 4'd0;
      r_stock  <= 4'(STOCK_INIT);
    end else begin
      r_state  <= w_state_next;
      r_credit <= w_credit_next;
      r_stock  <= w_stock_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_credit_next = r_credit;
    w_stock_next  = r_stock;
    case (r_state)
      IDLE: begin
        if (w_coin_ok) begin
          w_credit_next = w_credit_add;
          w_state_next  = (w_credit_add >= PRICE) ? VEND : CREDIT;
        end
      end
      CREDIT: begin
        if (w_coin_ok) begin
          w_credit_next = w_credit_add;
        end
        // Refund wins over reaching the price: the freshly added coin is returned too.
        if (refund_i) begin
          w_state_next = CHANGE;
        end else if (w_coin_ok) begin
          w_state_next = (w_credit_add >= PRICE) ? VEND : CREDIT;
        end else if (w_tmo_hit) begin
          w_state_next = CHANGE;
        end
      end
      VEND: begin
        if (vend_ack_i) begin
          w_credit_next = w_credit_left;
          if (r_stock != 4'd0) begin
            w_stock_next = r_stock - 4'd1;
          end
          w_state_next = (w_credit_left != 4'd0) ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        if (r_credit != 4'd0) begin
          w_credit_next = r_credit - 4'd1;
        end
        if (r_credit <= 4'd1) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign vend_req_o    = (r_state == VEND);
  assign change_o      = (r_state == CHANGE) && (r_credit != 4'd0);
  assign coin_reject_o = w_coin_any && !w_coin_ok;
  assign credit_o      = r_credit;
  assign stock_o       = r_stock;
  assign sold_out_o    = (r_stock == 4'd0);
  assign busy_o        = (r_state == VEND) || (r_state == CHANGE);

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller (PRICE 4, STOCK 8): coin paths, vend/ack, change, refund, reset, sell-out.
module tb_vend_controller;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       nickle_i;
  logic       dime_i;
  logic       quarter_i;
  logic       refund_i;
  logic       vend_ack_i;
  logic       vend_req_o;
  logic       change_o;
  logic       coin_reject_o;
  logic [3:0] credit_o;
  logic [3:0] stock_o;
  logic       sold_out_o;
  logic       busy_o;

  int total = 0;
  int bad   = 0;
  int pulses;
  int req_seen;
  int exp_pulses;
  int exp_credit;

  vend_controller #(
    .PRICE_NICKELS(4),
    .STOCK_INIT   (8),
    .TIMEOUT_CYC  (10)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .nickle_i     (nickle_i),
    .dime_i       (dime_i),
    .quarter_i    (quarter_i),
    .refund_i     (refund_i),
    .vend_ack_i   (vend_ack_i),
    .vend_req_o   (vend_req_o),
    .change_o     (change_o),
    .coin_reject_o(coin_reject_o),
    .credit_o     (credit_o),
    .stock_o      (stock_o),
    .sold_out_o   (sold_out_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic release_pulses();
    nickle_i   = 1'b0;
    dime_i     = 1'b0;
    quarter_i  = 1'b0;
    refund_i   = 1'b0;
    vend_ack_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    release_pulses();
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    chk("rst_credit", 8'(credit_o), 8'd0);
    chk("rst_stock", 8'(stock_o), 8'd8);
    chk("rst_req", 8'(vend_req_o), 8'd0);
    chk("rst_change", 8'(change_o), 8'd0);
    chk("rst_busy", 8'(busy_o), 8'd0);
    chk("rst_soldout", 8'(sold_out_o), 8'd0);
    chk("rst_reject", 8'(coin_reject_o), 8'd0);

    // ack outside VEND is ignored
    vend_ack_i = 1'b1; tick(); release_pulses();
    chk("ack_idle_stock", 8'(stock_o), 8'd8);
    chk("ack_idle_req", 8'(vend_req_o), 8'd0);

    // dime, dime -> exact price
    dime_i = 1'b1; #1;
    chk("dime1_reject", 8'(coin_reject_o), 8'd0);
    tick(); release_pulses();
    chk("dime1_credit", 8'(credit_o), 8'd2);
    chk("dime1_req", 8'(vend_req_o), 8'd0);
    dime_i = 1'b1; tick(); release_pulses();
    chk("dime2_credit", 8'(credit_o), 8'd4);
    chk("dime2_req", 8'(vend_req_o), 8'd1);
    chk("dime2_busy", 8'(busy_o), 8'd1);
    nickle_i = 1'b1; #1;
    chk("vend_coin_reject", 8'(coin_reject_o), 8'd1);
    tick(); release_pulses();
    chk("vend_coin_credit", 8'(credit_o), 8'd4);
    refund_i = 1'b1; tick(); release_pulses();
    chk("vend_refund_req", 8'(vend_req_o), 8'd1);
    vend_ack_i = 1'b1; tick(); release_pulses();
    chk("ack_req", 8'(vend_req_o), 8'd0);
    chk("ack_stock", 8'(stock_o), 8'd7);
    chk("ack_credit", 8'(credit_o), 8'd0);
    chk("ack_change", 8'(change_o), 8'd0);
    chk("ack_busy", 8'(busy_o), 8'd0);

    // quarter -> vend, one nickel of change
    quarter_i = 1'b1; tick(); release_pulses();
    chk("q_credit", 8'(credit_o), 8'd5);
    chk("q_req", 8'(vend_req_o), 8'd1);
    vend_ack_i = 1'b1; tick(); release_pulses();
    chk("q_ack_stock", 8'(stock_o), 8'd6);
    chk("q_ack_credit", 8'(credit_o), 8'd1);
    chk("q_ack_change", 8'(change_o), 8'd1);
    tick();
    chk("q_done_change", 8'(change_o), 8'd0);
    chk("q_done_credit", 8'(credit_o), 8'd0);
    chk("q_done_busy", 8'(busy_o), 8'd0);

    // nickel, dime, refund -> 3 nickels back
    nickle_i = 1'b1; tick(); release_pulses();
    dime_i = 1'b1; tick(); release_pulses();
    chk("nd_credit", 8'(credit_o), 8'd3);
    refund_i = 1'b1; tick(); release_pulses();
    chk("refund_first_change", 8'(change_o), 8'd1);
    pulses = 0;
    req_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (change_o) pulses++;
      if (vend_req_o) req_seen++;
      tick();
    end
    chk("refund_pulses", 8'(pulses), 8'd3);
    chk("refund_no_req", 8'(req_seen), 8'd0);
    chk("refund_credit", 8'(credit_o), 8'd0);
    chk("refund_busy", 8'(busy_o), 8'd0);

    // two coins at once rejected
    nickle_i = 1'b1; dime_i = 1'b1; #1;
    chk("multi_reject", 8'(coin_reject_o), 8'd1);
    tick(); release_pulses();
    chk("multi_credit", 8'(credit_o), 8'd0);
    chk("multi_busy", 8'(busy_o), 8'd0);

    // coin with refund in CREDIT: new credit fully returned, no vend
    nickle_i = 1'b1; tick(); release_pulses();
    dime_i = 1'b1; refund_i = 1'b1; #1;
    chk("coinref_reject", 8'(coin_reject_o), 8'd0);
    tick(); release_pulses();
    chk("coinref_credit", 8'(credit_o), 8'd3);
    chk("coinref_change", 8'(change_o), 8'd1);
    chk("coinref_req", 8'(vend_req_o), 8'd0);
    tick();
    chk("coinref_credit2", 8'(credit_o), 8'd2);

    // reset mid-CHANGE
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    chk("midrst_credit", 8'(credit_o), 8'd0);
    chk("midrst_change", 8'(change_o), 8'd0);
    chk("midrst_stock", 8'(stock_o), 8'd8);

    // idle in CREDIT
`ifdef VEND_TIMEOUT_EN
    exp_pulses = 1;
    exp_credit = 0;
`else
    exp_pulses = 0;
    exp_credit = 1;
`endif
    nickle_i = 1'b1; tick(); release_pulses();
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      if (change_o) pulses++;
      tick();
    end
    chk("idle_pulses", 8'(pulses), 8'(exp_pulses));
    chk("idle_credit", 8'(credit_o), 8'(exp_credit));
    refund_i = 1'b1; tick(); release_pulses();
    tick();
    chk("idle_clear_credit", 8'(credit_o), 8'd0);
    chk("idle_clear_busy", 8'(busy_o), 8'd0);

    // drain all stock with quarters
    for (int k = 0; k < 8; k++) begin
      quarter_i = 1'b1; tick(); release_pulses();
      vend_ack_i = 1'b1; tick(); release_pulses();
      chk("drain_stock", 8'(stock_o), 8'(7 - k));
      tick();
    end
    chk("soldout", 8'(sold_out_o), 8'd1);
    quarter_i = 1'b1; #1;
    chk("soldout_reject", 8'(coin_reject_o), 8'd1);
    tick(); release_pulses();
    chk("soldout_credit", 8'(credit_o), 8'd0);
    chk("soldout_req", 8'(vend_req_o), 8'd0);
    chk("soldout_busy", 8'(busy_o), 8'd0);
    chk("soldout_stock", 8'(stock_o), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
